// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch (I) and data (D) ports.
// Define FETCH_STARVE_GUARD_EN to let a starved fetch win once after STARVE_MAX D grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              RESET_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_pipe,
    output logic              busy
);

    typedef enum logic [1:0] { IDLE, WAIT, RESP } state_t;
    typedef enum logic { OWNER_I = 1'b0, OWNER_D = 1'b1 } owner_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state, stateNext;
    owner_t     owner;
    logic [3:0] cnt;
    logic       favourFetch;
    logic       grantD, grantI;

    // Grants are only made from IDLE; D wins ties unless the fetch guard has tripped.
    assign grantD = (state == IDLE) && dm_req && !favourFetch;
    assign grantI = (state == IDLE) && if_req && (!dm_req || favourFetch);

`ifdef FETCH_STARVE_GUARD_EN
    localparam int STARVE_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve;

    assign favourFetch = if_req && (starve == STARVE_LIM);

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (grantI || !if_req)
                starve <= '0;
            else if (grantD && (starve != STARVE_LIM))
                starve <= starve + 1'b1;
        end
    end
`else
    assign favourFetch = 1'b0;
`endif

    // NOTE: clocked blocks use non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // NOTE: the default is assigned before the case, so no path leaves stateNext unassigned (no latch).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantD || grantI) stateNext = WAIT;
            WAIT:    if (cnt == 4'd0) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: the read-data registers are reset with everything else, so no X ever reaches a requester.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            owner     <= OWNER_I;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantD) begin
                        owner     <= OWNER_D;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_we    <= dm_we;
                        mem_en    <= 1'b1;
                        cnt       <= CNT_INIT;
                    end else if (grantI) begin
                        owner    <= OWNER_I;
                        mem_addr <= if_addr;
                        mem_en   <= 1'b1;
                        cnt      <= CNT_INIT;
                    end
                end
                WAIT: begin
                    // The ack is raised here so it is high for exactly the RESP cycle.
                    if (cnt == 4'd0) begin
                        if (owner == OWNER_D) begin
                            dm_rdata <= mem_rdata;
                            dm_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_if   = if_req & ~if_ack;
    assign stall_pipe = dm_req & ~dm_ack;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and a randomized run against
// a transaction-level model; honours FETCH_STARVE_GUARD_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_pipe, busy;

    // Second requester set for the latency-1 and latency-15 instances.
    logic        ifReqL1, ifReqL15, zBit;
    logic [31:0] ifAddr6, zWord;
    logic [31:0] ifRdataL1, dmRdataL1, memAddrL1, memWdataL1, memRdataL1;
    logic        ifAckL1, dmAckL1, memEnL1, memWeL1, stallIfL1, stallPipeL1, busyL1;
    logic [31:0] ifRdataL15, dmRdataL15, memAddrL15, memWdataL15, memRdataL15;
    logic        ifAckL15, dmAckL15, memEnL15, memWeL15, stallIfL15, stallPipeL15, busyL15;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .RESET_N(rstN),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_pipe(stall_pipe), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_lat1 (
        .clk(clk), .RESET_N(rstN),
        .if_req(ifReqL1), .if_addr(ifAddr6), .if_rdata(ifRdataL1), .if_ack(ifAckL1),
        .dm_req(zBit), .dm_we(zBit), .dm_addr(zWord), .dm_wdata(zWord),
        .dm_rdata(dmRdataL1), .dm_ack(dmAckL1),
        .mem_en(memEnL1), .mem_we(memWeL1), .mem_addr(memAddrL1), .mem_wdata(memWdataL1),
        .mem_rdata(memRdataL1), .stall_if(stallIfL1), .stall_pipe(stallPipeL1), .busy(busyL1)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15), .STARVE_MAX(STARVE_MAX)) u_lat15 (
        .clk(clk), .RESET_N(rstN),
        .if_req(ifReqL15), .if_addr(ifAddr6), .if_rdata(ifRdataL15), .if_ack(ifAckL15),
        .dm_req(zBit), .dm_we(zBit), .dm_addr(zWord), .dm_wdata(zWord),
        .dm_rdata(dmRdataL15), .dm_ack(dmAckL15),
        .mem_en(memEnL15), .mem_we(memWeL15), .mem_addr(memAddrL15), .mem_wdata(memWdataL15),
        .mem_rdata(memRdataL15), .stall_if(stallIfL15), .stall_pipe(stallPipeL15), .busy(busyL15)
    );

    // Memory models: data is driven only in the cycle MEM_LAT-1 after the mem_en cycle.
    logic [31:0] memArr [0:255];
    logic [4:0]  enAge  = 5'd31;
    logic [4:0]  ageL1  = 5'd31;
    logic [4:0]  ageL15 = 5'd31;
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = 8'd0;
    logic [31:0] pokeData = 32'd0;

    always @(posedge clk) begin
        if (pokeEn)
            memArr[pokeAddr] <= pokeData;
        else if (mem_en && mem_we)
            memArr[mem_addr[7:0]] <= mem_wdata;
        enAge  <= mem_en   ? 5'd1 : ((enAge  == 5'd31) ? enAge  : enAge  + 5'd1);
        ageL1  <= memEnL1  ? 5'd1 : ((ageL1  == 5'd31) ? ageL1  : ageL1  + 5'd1);
        ageL15 <= memEnL15 ? 5'd1 : ((ageL15 == 5'd31) ? ageL15 : ageL15 + 5'd1);
    end

    assign mem_rdata   = ((mem_en ? 5'd0 : enAge) == 5'(LAT - 1)) ? memArr[mem_addr[7:0]] : 32'hBAD0_BAD0;
    assign memRdataL1  = ((memEnL1 ? 5'd0 : ageL1) == 5'd0) ? {16'h6000, memAddrL1[15:0]} : 32'hBAD0_BAD0;
    assign memRdataL15 = ((memEnL15 ? 5'd0 : ageL15) == 5'd14) ? {16'h6000, memAddrL15[15:0]} : 32'hBAD0_BAD0;

    // Protocol monitors sampled on the rising edge (pre-update values).
    int          enCount = 0, enCountL15 = 0, weViol = 0, bothAck = 0;
    logic [31:0] lastEnAddr = 32'd0, lastEnWdata = 32'd0;
    logic        lastEnWe = 1'b0;

    always @(posedge clk) begin
        if (mem_en) begin
            enCount     <= enCount + 1;
            lastEnAddr  <= mem_addr;
            lastEnWdata <= mem_wdata;
            lastEnWe    <= mem_we;
        end
        if (memEnL15) enCountL15 <= enCountL15 + 1;
        if (mem_we && !mem_en) weViol <= weViol + 1;
        if (if_ack && dm_ack) bothAck <= bothAck + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        tick();
        pokeEn   = 1'b0;
    endtask

    task automatic drain();
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
    endtask

    // One request on an idle arbiter; lat is the number of rising edges until the ack is seen.
    task automatic runReq(input bit isD, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output int stallBad);
        lat = 0;
        stallBad = 0;
        rdata = 32'h0;
        if (isD) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        if ((isD ? stall_pipe : stall_if) !== 1'b1) stallBad++;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if ((isD ? dm_ack : if_ack) === 1'b1) begin
                lat   = n;
                rdata = isD ? dm_rdata : if_rdata;
                if ((isD ? stall_pipe : stall_if) !== 1'b0) stallBad++;
                break;
            end
            if ((isD ? stall_pipe : stall_if) !== 1'b1) stallBad++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        bit          doPreload;
        int          expLat;
        logic [31:0] expRdata;
        bit          chkRdata;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] modelMem [16];

    initial begin
        int          lat, stallBad, enBefore, acks, viol, n1, n2;
        logic [31:0] rd, d1, d2;
        logic [10:0] seqBits, expSeq;
        int          seqCount, ifAckCount;
        bit          doneL1, doneL15, ownD, expChk, expI, expD, favI;
        int          latL1, latL15, nextFree, ackEdge, starveM;
        logic [31:0] dataL1, dataL15, expData;

        // Fields: isD, we, addr, wdata, preload, doPreload, expLat, expRdata, chkRdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, LAT + 1, 32'hDEAD_BEEF, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0,         1'b0, LAT + 1, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'h0,         1'b0, LAT + 1, 32'h0000_1234, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b1, LAT + 1, 32'h0,         1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b1, LAT + 1, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'hABCD_0077, 32'h0,         32'hA5A5_A5A5, 1'b1, LAT + 1, 32'hA5A5_A5A5, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_00FF, 32'hCAFE_F00D, 32'h0,         1'b0, LAT + 1, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0,         32'h0,         1'b0, LAT + 1, 32'hCAFE_F00D, 1'b1};

        rstN = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        ifReqL1 = 1'b0; ifReqL15 = 1'b0; ifAddr6 = 32'h0; zBit = 1'b0; zWord = 32'h0;
        #1;
        check("reset_ctrl", {if_ack, dm_ack, mem_en, mem_we, busy, stall_if, stall_pipe}, 7'b0);
        check("reset_data", {mem_addr, mem_wdata}, 64'h0);
        check("reset_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Single-request vectors on the latency-2 instance.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].doPreload) poke(vecs[v].addr[7:0], vecs[v].preload);
            enBefore = enCount;
            runReq(vecs[v].isD, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, rd, stallBad);
            check($sformatf("vec%0d_latency", v), lat, vecs[v].expLat);
            check($sformatf("vec%0d_stall", v), stallBad, 0);
            check($sformatf("vec%0d_en_count", v), enCount - enBefore, 1);
            check($sformatf("vec%0d_mem_addr_we", v), {lastEnAddr, 31'h0, lastEnWe}, {vecs[v].addr, 31'h0, vecs[v].we});
            if (vecs[v].chkRdata) check($sformatf("vec%0d_rdata", v), rd, vecs[v].expRdata);
            if (vecs[v].we) begin
                check($sformatf("vec%0d_mem_wdata", v), lastEnWdata, vecs[v].wdata);
                check($sformatf("vec%0d_stored", v), memArr[vecs[v].addr[7:0]], vecs[v].wdata);
            end
        end

        // Simultaneous requests: D first, fetch on the following IDLE.
        poke(8'h30, 32'h3030_3030);
        poke(8'h31, 32'h3131_3131);
        if_req = 1'b1; if_addr = 32'h30;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h31;
        n1 = 0; n2 = 0; d1 = 32'h0; d2 = 32'h0; stallBad = 0;
        #1;
        if (stall_if !== 1'b1) stallBad++;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (dm_ack === 1'b1) begin n1 = n; d1 = dm_rdata; dm_req = 1'b0; end
            if (if_ack === 1'b1) begin n2 = n; d2 = if_rdata; if_req = 1'b0; break; end
            if (stall_if !== 1'b1) stallBad++;
        end
        check("both_dm_ack_cycle", n1, LAT + 1);
        check("both_if_ack_cycle", n2, 2 * LAT + 3);
        check("both_rdata", {d1, d2}, {32'h3131_3131, 32'h3030_3030});
        check("both_stall_if", stallBad, 0);
        drain();
        tick();

        // Continuous D traffic with a pending fetch.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h41;
        seqBits = 11'b0; seqCount = 0; ifAckCount = 0;
        for (int n = 1; n <= 44; n++) begin
            tick();
            if (dm_ack === 1'b1 || if_ack === 1'b1) begin
                seqBits = {seqBits[9:0], if_ack};
                seqCount++;
            end
            if (if_ack === 1'b1) begin
                ifAckCount++;
                if_req = 1'b0;
            end
        end
`ifdef FETCH_STARVE_GUARD_EN
        expSeq = 11'b000_0100_0000;
`else
        expSeq = 11'b0;
`endif
        check("starve_ack_order", seqBits, expSeq);
        check("starve_ack_count", seqCount, 11);
        drain();
        tick();

        // Reset asserted in the first WAIT cycle aborts the access.
        poke(8'h50, 32'h5050_5050);
        if_req = 1'b1; if_addr = 32'h50;
        tick();
        check("abort_in_wait", {busy, mem_en}, 2'b11);
        rstN = 1'b0;
        #1;
        check("abort_ctrl", {if_ack, dm_ack, mem_en, mem_we, busy}, 5'b0);
        check("abort_data", {mem_addr, if_rdata}, 64'h0);
        if_req = 1'b0;
        tick();
        rstN = 1'b1;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (if_ack === 1'b1 || dm_ack === 1'b1) acks++;
        end
        check("abort_no_late_ack", {acks, 31'h0, busy}, 64'h0);
        runReq(1'b0, 1'b0, 32'h50, 32'h0, lat, rd, stallBad);
        check("abort_retry", {lat, rd}, {32'(LAT + 1), 32'h5050_5050});

        // Latency extremes with the fetch address toggling every cycle.
        ifReqL1 = 1'b1; ifReqL15 = 1'b1; ifAddr6 = 32'h100;
        doneL1 = 1'b0; doneL15 = 1'b0; latL1 = 0; latL15 = 0; dataL1 = 32'h0; dataL15 = 32'h0; viol = 0;
        enBefore = enCountL15;
        for (int n = 1; n <= 24 && !(doneL1 && doneL15); n++) begin
            tick();
            if (!doneL1) begin
                if (busyL1 && memAddrL1 !== 32'h100) viol++;
                if (ifAckL1 === 1'b1) begin latL1 = n; dataL1 = ifRdataL1; doneL1 = 1'b1; ifReqL1 = 1'b0; end
            end
            if (!doneL15) begin
                if (busyL15 && memAddrL15 !== 32'h100) viol++;
                if (ifAckL15 === 1'b1) begin latL15 = n; dataL15 = ifRdataL15; doneL15 = 1'b1; ifReqL15 = 1'b0; end
            end
            ifAddr6 = ifAddr6 ^ 32'h0000_FFFF;
        end
        check("lat1_latency", latL1, 2);
        check("lat15_latency", latL15, 16);
        check("lat_rdata", {dataL1, dataL15}, {32'h6000_0100, 32'h6000_0100});
        check("lat_addr_stable", viol, 0);
        check("lat15_single_en", enCountL15 - enBefore, 1);
        tick();
        tick();

        // Randomized traffic against a transaction-level model.
        for (int a = 0; a < 16; a++) begin
            modelMem[a] = $urandom;
            poke(8'(a), modelMem[a]);
        end
        nextFree = 0; ackEdge = -100; starveM = 0; ownD = 1'b0; expChk = 1'b0; expData = 32'h0;
        for (int e = 1; e <= 600; e++) begin
            @(posedge clk);
            if (e >= nextFree) begin
                if (!if_req) starveM = 0;
                if (if_req || dm_req) begin
                    favI = 1'b0;
`ifdef FETCH_STARVE_GUARD_EN
                    favI = if_req && (starveM == STARVE_MAX);
`endif
                    ownD = dm_req && !favI;
                    if (!ownD) starveM = 0;
                    else if (if_req && starveM < STARVE_MAX) starveM++;
                    ackEdge  = e + LAT;
                    nextFree = e + LAT + 2;
                    expData  = modelMem[ownD ? dm_addr[3:0] : if_addr[3:0]];
                    expChk   = !(ownD && dm_we);
                    if (ownD && dm_we) modelMem[dm_addr[3:0]] = dm_wdata;
                end
            end
            @(negedge clk);
            expI = (e == ackEdge) && !ownD;
            expD = (e == ackEdge) && ownD;
            check("rand_acks", {if_ack, dm_ack}, {expI, expD});
            check("rand_stalls", {stall_if, stall_pipe}, {if_req & ~expI, dm_req & ~expD});
            check("rand_busy", busy, (e < nextFree - 1));
            if ((expI || expD) && expChk)
                check("rand_rdata", expI ? if_rdata : dm_rdata, expData);
            if (if_req && if_ack) if_req = 1'b0;
            if (!if_req && $urandom_range(2, 0) == 0) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(15, 0));
            end
            if (dm_req && dm_ack) dm_req = 1'b0;
            if (!dm_req && $urandom_range(2, 0) == 0) begin
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(1, 0));
                dm_addr  = 32'($urandom_range(15, 0));
                dm_wdata = $urandom;
            end
        end
        drain();
        tick();

        check("mem_we_outside_en", weViol, 0);
        check("acks_overlap", bothAck, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
